pipe_fetch: RTL and testbench



---
 rtl/pipe_fetch_pkg.sv | 27 ++
 rtl/instr_rom.sv | 31 +++
 rtl/pipe_fetch.sv | 68 ++++++
 tb/tb_pipe_fetch.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_fetch_pkg.sv
// pipe_fetch_pkg: shared constants and ROM image for the instruction-fetch stage.
//   DATA_W_DEF / ADDR_BITS_DEF : default instruction/PC width and log2 ROM depth
//   OPC_J                      : opcode of the absolute jump (J)
//   PC_STEP / RESET_PC         : PC increment and value loaded on reset
//   rom_init_word()            : elaboration-time ROM contents per word index
package pipe_fetch_pkg;

  localparam int unsigned DATA_W_DEF    = 32;
  localparam int unsigned ADDR_BITS_DEF = 6;
  localparam logic [5:0]  OPC_J         = 6'b000010;
  localparam int unsigned PC_STEP       = 4;
  localparam int unsigned RESET_PC      = 0;

  // Words 0..14 hold their own index, word 15 jumps back to address 0,
  // everything above is zero.
  function automatic logic [31:0] rom_init_word(input int k);
    logic [31:0] w;
    w = '0;
    if (k >= 0 && k < 15) begin
      w = 32'(k);
    end else if (k == 15) begin
      w = 32'h0800_0000;
    end
    return w;
  endfunction

endpackage

// File: rtl/instr_rom.sv
// instr_rom: fixed-content instruction memory with combinational read.
//   addr : word address (DEPTH_BITS wide)
//   data : instruction word at addr (WIDTH wide), valid in the same cycle
// OVR_EN/OVR_IDX/OVR_WORD replace a single word of the image, giving test
// programs a way to plant an instruction without editing the default image.
module instr_rom
  import pipe_fetch_pkg::*;
#(
  parameter int unsigned      WIDTH      = DATA_W_DEF,
  parameter int unsigned      DEPTH_BITS = ADDR_BITS_DEF,
  parameter bit               OVR_EN     = 1'b0,
  parameter int               OVR_IDX    = 0,
  parameter logic [WIDTH-1:0] OVR_WORD   = '0
) (
  input  logic [DEPTH_BITS-1:0] addr,
  output logic [WIDTH-1:0]      data
);

  logic [WIDTH-1:0] mem [2**DEPTH_BITS];

  for (genvar k = 0; k < 2**DEPTH_BITS; k++) begin : g_word
    if (OVR_EN && (k == OVR_IDX)) begin : g_ovr
      assign mem[k] = OVR_WORD;
    end else begin : g_img
      assign mem[k] = WIDTH'(rom_init_word(k));
    end
  end

  assign data = mem[addr];

endmodule

// File: rtl/pipe_fetch.sv
// pipe_fetch: instruction-fetch stage (PC, ROM, PC+4 adder, J redirect, IF/ID).
//   clk    : system clock, all state updates on the rising edge
//   inicio : synchronous active-high reset
//   Test   : parity (XOR-reduction) of the instruction held in IF/ID
// The PC advances every non-reset cycle; there is no stall or flush.
module pipe_fetch
  import pipe_fetch_pkg::*;
#(
  parameter int unsigned       DATA_W       = DATA_W_DEF,
  parameter int unsigned       ADDR_BITS    = ADDR_BITS_DEF,
  parameter bit                ROM_OVR_EN   = 1'b0,
  parameter int                ROM_OVR_IDX  = 0,
  parameter logic [DATA_W-1:0] ROM_OVR_WORD = '0
) (
  input  logic clk,
  input  logic inicio,
  output logic Test
);

  logic [DATA_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ifid_instr_q, ifid_instr_d;
  logic [DATA_W-1:0] ifid_pc4_q, ifid_pc4_d;
  logic [DATA_W-1:0] instr;
  logic [DATA_W-1:0] pc4;
  logic              unused_ifid_pc4;

  // PC[1:0] is dropped and upper bits alias, so fetch wraps over the ROM.
  instr_rom #(
    .WIDTH      (DATA_W),
    .DEPTH_BITS (ADDR_BITS),
    .OVR_EN     (ROM_OVR_EN),
    .OVR_IDX    (ROM_OVR_IDX),
    .OVR_WORD   (ROM_OVR_WORD)
  ) u_rom (
    .addr (pc_q[ADDR_BITS+1:2]),
    .data (instr)
  );

  always_comb begin
    pc4          = pc_q + DATA_W'(PC_STEP);
    pc_d         = pc4;
    // J redirects in the cycle it is fetched; the J itself still enters IF/ID.
    if (instr[DATA_W-1 -: 6] == OPC_J) begin
      pc_d = {pc4[DATA_W-1 -: 4], instr[DATA_W-7:0], 2'b00};
    end
    ifid_instr_d = instr;
    ifid_pc4_d   = pc4;
  end

  always_ff @(posedge clk) begin
    if (inicio) begin
      pc_q         <= DATA_W'(RESET_PC);
      ifid_instr_q <= '0;
      ifid_pc4_q   <= '0;
    end else begin
      pc_q         <= pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc4_q   <= ifid_pc4_d;
    end
  end

  assign Test = ^ifid_instr_q;

  // IF/ID PC+4 is consumed by later pipeline stages, which are not part of
  // this block.
  assign unused_ifid_pc4 = ^ifid_pc4_q;

endmodule

// File: tb/tb_pipe_fetch.sv
// tb_pipe_fetch: self-checking bench for pipe_fetch. Two instances share the
// clock and reset: dut (default ROM) and dut_ovr (word 5 = J to byte 64).
module tb_pipe_fetch;

  logic clk = 1'b0;
  logic inicio = 1'b1;
  logic test_a, test_b;

  int checks = 0;
  int errors = 0;

  always #1 clk = ~clk;

  pipe_fetch #(.DATA_W(32), .ADDR_BITS(6)) dut (
    .clk    (clk),
    .inicio (inicio),
    .Test   (test_a)
  );

  pipe_fetch #(
    .DATA_W       (32),
    .ADDR_BITS    (6),
    .ROM_OVR_EN   (1'b1),
    .ROM_OVR_IDX  (5),
    .ROM_OVR_WORD (32'h0800_0010)
  ) dut_ovr (
    .clk    (clk),
    .inicio (inicio),
    .Test   (test_b)
  );

  // Reference model: program image plus architectural PC and IF/ID word.
  logic [31:0] m_rom  [2][64];
  logic [31:0] m_pc   [2];
  logic [31:0] m_ifid [2];

  initial begin
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 64; k++) begin
        m_rom[d][k] = (k < 15) ? 32'(k) : ((k == 15) ? 32'h0800_0000 : 32'h0);
      end
      m_pc[d]   = 32'h0;
      m_ifid[d] = 32'h0;
    end
    m_rom[1][5] = 32'h0800_0010;
  end

  // One clock edge: drive reset, advance the model at the edge, return at
  // the following falling edge where outputs are sampled.
  task automatic cycle(input logic r);
    logic [31:0] fetched, nxt;
    inicio = r;
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (r) begin
        m_pc[d]   = 32'h0;
        m_ifid[d] = 32'h0;
      end else begin
        fetched = m_rom[d][(m_pc[d] / 4) % 64];
        nxt     = m_pc[d] + 32'd4;
        if (fetched[31:26] == 6'd2) nxt = {nxt[31:28], fetched[25:0], 2'b00};
        m_ifid[d] = fetched;
        m_pc[d]   = nxt;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    cycle(1'b1);
    checks++;
    if (test_a !== 1'b0) begin
      errors++; $display("FAIL reset_test: got %b want 0", test_a);
    end
    checks++;
    if (dut.pc_q !== 32'h0) begin
      errors++; $display("FAIL reset_pc: got %h want 0", dut.pc_q);
    end
    checks++;
    if (dut.ifid_instr_q !== 32'h0) begin
      errors++; $display("FAIL reset_ifid: got %h want 0", dut.ifid_instr_q);
    end
    checks++;
    if (test_b !== 1'b0) begin
      errors++; $display("FAIL reset_test_ovr: got %b want 0", test_b);
    end
  endtask

  // 20 edges after release: fixed parity/PC sequence, wrap via J at word 15,
  // no X on Test and PC never beyond 60.
  task automatic test_sequence();
    logic        exp_t [20];
    logic [31:0] exp_pc [20];
    exp_t = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0,
              1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int e = 1; e <= 20; e++) begin
      exp_pc[e-1] = (e <= 15) ? 32'(4 * e) : 32'(4 * (e - 16));
    end
    for (int e = 1; e <= 20; e++) begin
      cycle(1'b0);
      checks++;
      if ($isunknown(test_a)) begin
        errors++; $display("FAIL seq_x edge %0d: got %b want known", e, test_a);
      end
      checks++;
      if (test_a !== exp_t[e-1]) begin
        errors++; $display("FAIL seq_test edge %0d: got %b want %b", e, test_a, exp_t[e-1]);
      end
      checks++;
      if (dut.pc_q !== exp_pc[e-1]) begin
        errors++; $display("FAIL seq_pc edge %0d: got %0d want %0d", e, dut.pc_q, exp_pc[e-1]);
      end
      checks++;
      if (dut.pc_q > 32'd60) begin
        errors++; $display("FAIL seq_pc_range edge %0d: got %0d want <= 60", e, dut.pc_q);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    while (m_pc[0] != 32'd40 && n < 64) begin
      cycle(1'b0);
      n++;
    end
    checks++;
    if (dut.pc_q !== 32'd40) begin
      errors++; $display("FAIL mid_reach_pc40: got %0d want 40", dut.pc_q);
    end
    cycle(1'b1);
    checks++;
    if (dut.pc_q !== 32'h0 || dut.ifid_instr_q !== 32'h0 || test_a !== 1'b0) begin
      errors++; $display("FAIL mid_reset: got pc %0d ifid %h test %b want 0 0 0",
                         dut.pc_q, dut.ifid_instr_q, test_a);
    end
    cycle(1'b0);
    checks++;
    if (dut.pc_q !== 32'd4 || dut.ifid_instr_q !== 32'h0) begin
      errors++; $display("FAIL mid_refetch0: got pc %0d ifid %h want 4 0",
                         dut.pc_q, dut.ifid_instr_q);
    end
    cycle(1'b0);
    checks++;
    if (test_a !== 1'b1 || dut.ifid_instr_q !== 32'h1) begin
      errors++; $display("FAIL mid_refetch1: got test %b ifid %h want 1 1",
                         test_a, dut.ifid_instr_q);
    end
  endtask

  task automatic test_reset_on_jump();
    int n = 0;
    while (m_pc[0] != 32'd60 && n < 64) begin
      cycle(1'b0);
      n++;
    end
    checks++;
    if (dut.pc_q !== 32'd60) begin
      errors++; $display("FAIL jmp_reach_pc60: got %0d want 60", dut.pc_q);
    end
    cycle(1'b1);
    checks++;
    if (dut.pc_q !== 32'h0 || dut.ifid_instr_q !== 32'h0 || test_a !== 1'b0) begin
      errors++; $display("FAIL jmp_reset_wins: got pc %0d ifid %h test %b want 0 0 0",
                         dut.pc_q, dut.ifid_instr_q, test_a);
    end
  endtask

  task automatic test_override_jump();
    cycle(1'b1);
    for (int e = 0; e < 6; e++) cycle(1'b0);
    checks++;
    if (dut_ovr.pc_q !== 32'd64 || dut_ovr.ifid_instr_q !== 32'h0800_0010) begin
      errors++; $display("FAIL ovr_jump: got pc %0d ifid %h want 64 08000010",
                         dut_ovr.pc_q, dut_ovr.ifid_instr_q);
    end
    cycle(1'b0);
    checks++;
    if (test_b !== 1'b0 || dut_ovr.ifid_instr_q !== 32'h0 || dut_ovr.pc_q !== 32'd68) begin
      errors++; $display("FAIL ovr_alias: got test %b ifid %h pc %0d want 0 0 68",
                         test_b, dut_ovr.ifid_instr_q, dut_ovr.pc_q);
    end
    cycle(1'b0);
    checks++;
    if (dut_ovr.pc_q !== 32'd72) begin
      errors++; $display("FAIL ovr_incr: got pc %0d want 72", dut_ovr.pc_q);
    end
  endtask

  // Random reset pulses over long runs, both instances against the model.
  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      cycle(($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0);
      checks++;
      if (test_a !== ^m_ifid[0] || dut.pc_q !== m_pc[0] || dut.ifid_instr_q !== m_ifid[0]) begin
        errors++; $display("FAIL rnd_dut cyc %0d: got test %b pc %h ifid %h want %b %h %h",
                           c, test_a, dut.pc_q, dut.ifid_instr_q, ^m_ifid[0], m_pc[0], m_ifid[0]);
      end
      checks++;
      if (test_b !== ^m_ifid[1] || dut_ovr.pc_q !== m_pc[1] ||
          dut_ovr.ifid_instr_q !== m_ifid[1]) begin
        errors++; $display("FAIL rnd_ovr cyc %0d: got test %b pc %h ifid %h want %b %h %h",
                           c, test_b, dut_ovr.pc_q, dut_ovr.ifid_instr_q,
                           ^m_ifid[1], m_pc[1], m_ifid[1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_reset_mid();
    test_reset_on_jump();
    test_override_jump();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
